// File: rtl/mtimer_tresp.sv
// rtl/mtimer_tresp.sv - machine timer (mtime/mtimecmp) behind a one-entry request/response port
module mtimer_tresp #(
    parameter int unsigned C_PRESCALE = 1
) (
    input  logic        clk_i,
    input  logic        clk_en_i,
    input  logic        resetb_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic        treqdvalid_i,
    input  logic [31:0] treqaddr_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic [31:0] trspdata_o,
    output logic        irq_timer_o
);

    localparam logic [15:0] PRESC_LAST = 16'(C_PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q, irq_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        acc;
    logic        ret;
    logic        tick;
    logic        wr;
    logic [1:0]  sel;
    logic [31:0] rd_data;
    logic        unused_addr;

    assign unused_addr = ^{treqaddr_i[31:4], treqaddr_i[1:0]};

    // Handshake terms: the buffer frees up in the same cycle it is being drained
    assign treqready_o = ~rsp_valid_q | trspready_i;
    assign trspvalid_o = rsp_valid_q;
    assign trspdata_o  = rsp_data_q;
    assign irq_timer_o = irq_q;

    assign acc  = clk_en_i & treqvalid_i & treqready_o;
    assign ret  = clk_en_i & rsp_valid_q & trspready_i;
    assign tick = clk_en_i & (presc_q == PRESC_LAST);
    assign wr   = acc & treqdvalid_i;
    assign sel  = treqaddr_i[3:2];

    // Read mux returns the register contents as they stand before the accepting edge
    always_comb begin
        rd_data = 32'h0;
        case (sel)
            2'd0:    rd_data = mtime_q[31:0];
            2'd1:    rd_data = mtime_q[63:32];
            2'd2:    rd_data = mtimecmp_q[31:0];
            default: rd_data = mtimecmp_q[63:32];
        endcase
    end

    // Prescaler wraps after C_PRESCALE enabled cycles; the wrap cycle is the tick
    always_comb begin
        presc_d = presc_q;
        if (clk_en_i) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
    end

    // mtime: a write to either half suppresses that cycle's increment entirely
    always_comb begin
        mtime_d = mtime_q;
        if (wr && sel == 2'd0) begin
            mtime_d = {mtime_q[63:32], treqdata_i};
        end else if (wr && sel == 2'd1) begin
            mtime_d = {treqdata_i, mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // mtimecmp only changes through half-word writes
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr && sel == 2'd2) begin
            mtimecmp_d = {mtimecmp_q[63:32], treqdata_i};
        end else if (wr && sel == 2'd3) begin
            mtimecmp_d = {treqdata_i, mtimecmp_q[31:0]};
        end
    end

    // Interrupt compares the values the registers will hold after this edge
    always_comb begin
        irq_d = irq_q;
        if (clk_en_i) begin
            irq_d = (mtime_d >= mtimecmp_d);
        end
    end

    // Response buffer: a new acceptance overwrites a retiring entry for full throughput
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = treqdvalid_i ? 32'h0 : rd_data;
        end else if (ret) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset that overrides the clock enable
    always_ff @(posedge clk_i) begin
        if (!resetb_i) begin
            presc_q     <= 16'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            irq_q       <= irq_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
